// File: rtl/key_pkg.sv
// Shared keypad definitions: key code constants, scanner state encoding and
// the (row, column) -> key code lookup. The calculator core uses the same codes.
package key_pkg;

    localparam logic [3:0] KEY_0   = 4'd0;
    localparam logic [3:0] KEY_1   = 4'd1;
    localparam logic [3:0] KEY_2   = 4'd2;
    localparam logic [3:0] KEY_3   = 4'd3;
    localparam logic [3:0] KEY_4   = 4'd4;
    localparam logic [3:0] KEY_5   = 4'd5;
    localparam logic [3:0] KEY_6   = 4'd6;
    localparam logic [3:0] KEY_7   = 4'd7;
    localparam logic [3:0] KEY_8   = 4'd8;
    localparam logic [3:0] KEY_9   = 4'd9;
    localparam logic [3:0] KEY_EQ  = 4'd10;
    localparam logic [3:0] KEY_CLR = 4'd11;
    localparam logic [3:0] KEY_SUB = 4'd12;
    localparam logic [3:0] KEY_ADD = 4'd13;
    localparam logic [3:0] KEY_MUL = 4'd14;
    localparam logic [3:0] KEY_DIV = 4'd15;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        HOLD     = 2'd3
    } key_state_t;

    // True when exactly one active-low column bit is low.
    function automatic logic one_low(input logic [3:0] col);
        logic [3:0] act;
        logic [3:0] act_m1;
        act    = ~col;
        act_m1 = act - 4'd1;
        return (act != 4'd0) && ((act & act_m1) == 4'd0);
    endfunction

    // Index of the single low bit of a one-hot-low column pattern.
    function automatic logic [1:0] col_index(input logic [3:0] col);
        case (col)
            4'b1110: return 2'd0;
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    // Physical keypad layout.
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        case ({row, col})
            4'h0: return KEY_1;
            4'h1: return KEY_2;
            4'h2: return KEY_3;
            4'h3: return KEY_ADD;
            4'h4: return KEY_4;
            4'h5: return KEY_5;
            4'h6: return KEY_6;
            4'h7: return KEY_SUB;
            4'h8: return KEY_7;
            4'h9: return KEY_8;
            4'hA: return KEY_9;
            4'hB: return KEY_MUL;
            4'hC: return KEY_CLR;
            4'hD: return KEY_0;
            4'hE: return KEY_EQ;
            default: return KEY_DIV;
        endcase
    endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for the four asynchronous keypad columns.
// Resets to all ones (no column pulled low).
module key_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    // Two-stage capture of the raw column lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 4'hF;
            q    <= 4'hF;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_scan.sv
// 4x4 matrix keypad scanner/encoder. Drives one row low at a time, samples the
// synchronized columns, debounces a single press and emits a one-cycle flag
// with the key code on data (data holds its value between flags).
// Handshake: flag is a one-cycle valid with no ready; data is meaningful in the
// flag cycle and the consumer must take it then.
// Optional build macro: KEY_REPEAT_EN enables auto-repeat while a key is held.
module key_scan
    import key_pkg::*;
#(
    parameter int SCAN_CYC     = 4,
    parameter int DEB_CYC      = 20,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic       clk_1khz,
    input  logic       rst_n,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic       flag,
    output logic [3:0] data,
    output key_state_t dbg_state
);

    localparam int MAX_A = (SCAN_CYC > DEB_CYC) ? SCAN_CYC : DEB_CYC;
    localparam int MAX_B = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0] CNT_TOP   = {CW{1'b1}};
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYC - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYC - 1);

    key_state_t    state, next_state;
    logic [3:0]    col_s;
    logic [CW-1:0] cnt;
    logic [1:0]    row_q;
    logic [3:0]    col_lat;
    logic [3:0]    data_q;
    logic          rep_fire;

    key_sync u_sync (
        .clk   (clk_1khz),
        .rst_n (rst_n),
        .d     (col_n),
        .q     (col_s)
    );

    // State register.
    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) state <= SCAN;
        else        state <= next_state;
    end

    // Next-state decisions from the synchronized columns and the shared counter.
    always_comb begin
        next_state = state;
        case (state)
            SCAN:     if (cnt == SCAN_LAST && one_low(col_s)) next_state = DEBOUNCE;
            DEBOUNCE: begin
                if (col_s != col_lat)     next_state = SCAN;
                else if (cnt == DEB_LAST) next_state = PRESSED;
            end
            PRESSED:  next_state = HOLD;
            HOLD:     if (col_s == 4'hF && cnt == DEB_LAST) next_state = SCAN;
            default:  next_state = SCAN;
        endcase
    end

    // Counter, row pointer, latched column pattern and output code register.
    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            row_q   <= 2'd0;
            col_lat <= 4'hF;
            data_q  <= 4'd0;
        end else begin
            case (state)
                SCAN: begin
                    if (cnt == SCAN_LAST) begin
                        cnt <= '0;
                        if (next_state == DEBOUNCE) col_lat <= col_s;
                        else                        row_q   <= row_q + 2'd1;
                    end else if (cnt != CNT_TOP) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (next_state == SCAN) begin
                        cnt   <= '0;
                        row_q <= row_q + 2'd1;
                    end else if (next_state == PRESSED) begin
                        cnt    <= '0;
                        data_q <= key_code(row_q, col_index(col_lat));
                    end else if (cnt != CNT_TOP) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: cnt <= '0;
                default: begin
                    // HOLD: only an all-released pattern advances the release count.
                    if (next_state == SCAN) begin
                        cnt   <= '0;
                        row_q <= row_q + 2'd1;
                    end else if (col_s != 4'hF) begin
                        cnt <= '0;
                    end else if (cnt != CNT_TOP) begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef KEY_REPEAT_EN
    localparam logic [CW-1:0] REP_AT   = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] REP_BACK = CW'(REPEAT_DELAY - REPEAT_RATE + 1);

    logic [CW-1:0] rcnt;
    logic          rep_live;

    // rcnt equals cycles since the PRESSED cycle; repeating stops for good once
    // the held pattern changes (release started or another key joined).
    assign rep_fire = (state == HOLD) && rep_live && (col_s == col_lat) && (rcnt == REP_AT);

    // Auto-repeat timer.
    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            rcnt     <= '0;
            rep_live <= 1'b0;
        end else if (state == PRESSED) begin
            rcnt     <= CW'(1);
            rep_live <= 1'b1;
        end else if (state == HOLD) begin
            if (col_s != col_lat)   rep_live <= 1'b0;
            else if (rep_fire)      rcnt     <= REP_BACK;
            else if (rcnt != CNT_TOP) rcnt   <= rcnt + 1'b1;
        end else begin
            rep_live <= 1'b0;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    // Output decode from registered state.
    always_comb begin
        row_n     = ~(4'b0001 << row_q);
        flag      = (state == PRESSED) || rep_fire;
        data      = data_q;
        dbg_state = state;
    end

endmodule

// File: tb/tb_key_scan.sv
// Bench for key_scan: a keypad model drives col_n from the pressed-key matrix
// and the driven row; stimulus pushes expected codes, a monitor pops on flag.
`timescale 1ns/1ps
module tb_key_scan;
    import key_pkg::*;

    logic       clk_1khz;
    logic       rst_n;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic       flag;
    logic [3:0] data;
    key_state_t dbg_state;

    logic [15:0] keys;          // bit r*4+c: key at row r, column c held down
    logic [3:0]  exp_q[$];
    int          n_checks;
    int          n_pass;
    logic        prev_flag;

    key_scan dut (
        .clk_1khz  (clk_1khz),
        .rst_n     (rst_n),
        .col_n     (col_n),
        .row_n     (row_n),
        .flag      (flag),
        .data      (data),
        .dbg_state (dbg_state)
    );

    // Clock: 10 ns period.
    initial clk_1khz = 1'b0;
    always #5 clk_1khz = ~clk_1khz;

    // Keypad matrix: a held key shorts its column to its row when that row is low.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_1khz);
    endtask

    // Press one key, hold it, release it; the expected code is queued up front.
    task automatic press(input int r, input int c, input int hold, input int rel, input logic [3:0] code);
        exp_q.push_back(code);
        keys[r*4+c] = 1'b1;
        idle(hold);
        keys = 16'h0;
        idle(rel);
    endtask

    // Monitor / scoreboard: every flag is matched against the expected queue.
    initial begin
        prev_flag = 1'b0;
        forever begin
            @(negedge clk_1khz);
            if (flag) begin
                chk("flag_single_cycle", int'(prev_flag), 0);
                if (exp_q.size() == 0) chk("unexpected_flag", int'(data), -1);
                else                   chk("flag_data", int'(data), int'(exp_q.pop_front()));
            end
            prev_flag = flag;
        end
    end

    initial begin
        logic [3:0] exp_row;
        logic [3:0] seen;
        logic       found;
        n_checks = 0;
        n_pass   = 0;
        keys     = 16'h0;
        rst_n    = 1'b0;

        // Reset values.
        #200;
        @(negedge clk_1khz);
        chk("rst_row_n", int'(row_n), 4'b1110);
        chk("rst_flag", int'(flag), 0);
        chk("rst_data", int'(data), 0);
        chk("rst_state", int'(dbg_state), int'(SCAN));

        // Rows step r0..r3 and wrap, SCAN_CYC=4 cycles each.
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            #1;
            exp_row = ~(4'b0001 << ((k / 4) % 4));
            chk("row_scan", int'(row_n), int'(exp_row));
            @(negedge clk_1khz);
        end

        // Single press of '5'; no flag on release, data holds.
        press(1, 1, 60, 40, KEY_5);
        chk("data_holds", int'(data), int'(KEY_5));

        // Bouncing 'C' never debounces; then a stable press does.
        for (int b = 0; b < 4; b++) begin
            keys[12] = 1'b1;
            idle(10);
            keys[12] = 1'b0;
            idle(5);
        end
        press(3, 0, 60, 40, KEY_CLR);

        // Two keys in one row: ignored, scanning continues through every row.
        keys[0] = 1'b1;
        keys[3] = 1'b1;
        idle(20);
        seen = 4'h0;
        for (int k = 0; k < 20; k++) begin
            seen = seen | ~row_n;
            @(negedge clk_1khz);
        end
        chk("two_keys_rows_seen", int'(seen), 4'hF);
        keys = 16'h0;
        idle(40);

        // Long hold of '+'.
`ifdef KEY_REPEAT_EN
        exp_q.push_back(KEY_ADD);
        exp_q.push_back(KEY_ADD);
        exp_q.push_back(KEY_ADD);
`endif
        press(0, 3, 800, 40, KEY_ADD);

        // Reset in the middle of debouncing '2': no flag, reset values.
        keys[1] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk_1khz);
            if (dbg_state == DEBOUNCE) found = 1'b1;
        end
        chk("reach_debounce", int'(found), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_row_n", int'(row_n), 4'b1110);
        chk("midrst_flag", int'(flag), 0);
        chk("midrst_data", int'(data), 0);
        keys = 16'h0;
        #200;
        @(negedge clk_1khz);
        rst_n = 1'b1;
        idle(10);

        // Key sequence 5, 2, +, 2, 2, =.
        press(1, 1, 60, 40, KEY_5);
        press(0, 1, 60, 40, KEY_2);
        press(0, 3, 60, 40, KEY_ADD);
        press(0, 1, 60, 40, KEY_2);
        press(0, 1, 60, 40, KEY_2);
        press(3, 2, 60, 40, KEY_EQ);
        chk("data_last", int'(data), int'(KEY_EQ));

        idle(20);
        chk("flags_outstanding", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
